// File: rtl/set_less_arbiter_pkg.sv
// Shared types and constants for the set_less comparator arbiter.
// The stage struct carries one granted compare into the shared comparator.
package set_less_pkg;

    localparam int MAX_REQ = 8;
    localparam int DATA_W  = 32;
    localparam int ID_W    = $clog2(MAX_REQ);

    localparam logic [DATA_W-1:0] LESS_TRUE  = 32'h0000_0001;
    localparam logic [DATA_W-1:0] LESS_FALSE = 32'h0000_0000;

    typedef enum logic {
        CMP_SIGNED   = 1'b0,
        CMP_UNSIGNED = 1'b1
    } cmp_kind_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        cmp_kind_t         kind;
        logic [ID_W-1:0]   id;
    } stage_t;

endpackage

// File: rtl/set_less_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter (slave).
// Operand and result vectors pack requester i into bits [WIDTH*i +: WIDTH].
interface set_less_arbiter_if
    import set_less_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DATA_W
);

    logic [NUM_REQ-1:0]       i_ReqValid;
    logic [NUM_REQ*WIDTH-1:0] i_ReqA;
    logic [NUM_REQ*WIDTH-1:0] i_ReqB;
    logic [NUM_REQ-1:0]       i_ReqUnsigned;
    logic [NUM_REQ-1:0]       o_ReqReady;
    logic [NUM_REQ-1:0]       o_RspValid;
    logic [NUM_REQ*WIDTH-1:0] o_RspResult;
    logic [NUM_REQ-1:0]       i_RspReady;
    logic                     o_Busy;

    modport master (
        output i_ReqValid, i_ReqA, i_ReqB, i_ReqUnsigned, i_RspReady,
        input  o_ReqReady, o_RspValid, o_RspResult, o_Busy
    );

    modport slave (
        input  i_ReqValid, i_ReqA, i_ReqB, i_ReqUnsigned, i_RspReady,
        output o_ReqReady, o_RspValid, o_RspResult, o_Busy
    );

endinterface

// File: rtl/set_less.sv
// Combinational signed and unsigned less-than comparator.
module set_less #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_IsLess,
    output logic             o_IsLessUnsigned
);

    assign o_IsLess         = $signed(i_A) < $signed(i_B);
    assign o_IsLessUnsigned = i_A < i_B;

endmodule

// File: rtl/set_less_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters.
// The pointer holds the first index to search and moves only when a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(ptr_q) + k >= NUM_REQ) begin
                idx = PTR_W'(int'(ptr_q) + k - NUM_REQ);
            end else begin
                idx = PTR_W'(int'(ptr_q) + k);
            end
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/set_less_arbiter.sv
// Shares one set_less comparator between NUM_REQ requesters: arbitrate, register
// the granted operands, compare, and park each result in its requester's slot.
module set_less_arbiter
    import set_less_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DATA_W
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    set_less_arbiter_if.slave  bus
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   grant_sel;
    logic [WIDTH-1:0]   req_a [NUM_REQ];
    logic [WIDTH-1:0]   req_b [NUM_REQ];

    stage_t             stage_q;
    logic               is_less;
    logic               is_less_unsigned;
    logic               less;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0]   rsp_result_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_a[g] = bus.i_ReqA[g*WIDTH +: WIDTH];
        assign req_b[g] = bus.i_ReqB[g*WIDTH +: WIDTH];
        assign bus.o_RspResult[g*WIDTH +: WIDTH] = rsp_result_q[g];
    end

    // One op in flight per requester: busy while in the stage, or while its slot
    // stays full and is not being drained this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.i_ReqValid[i] && !i_Reset
                       && !(stage_q.valid && stage_q.id == ID_W'(i))
                       && (!rsp_valid_q[i] || bus.i_RspReady[i]);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .eligible (eligible),
        .grant    (grant)
    );

    always_comb begin
        grant_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_sel = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            stage_q <= '0;
        end else begin
            stage_q.valid <= |grant;
            if (|grant) begin
                stage_q.a    <= req_a[grant_sel];
                stage_q.b    <= req_b[grant_sel];
                stage_q.kind <= bus.i_ReqUnsigned[grant_sel] ? CMP_UNSIGNED : CMP_SIGNED;
                stage_q.id   <= ID_W'(grant_sel);
            end
        end
    end

    set_less #(
        .WIDTH (WIDTH)
    ) u_set_less (
        .i_A              (stage_q.a),
        .i_B              (stage_q.b),
        .o_IsLess         (is_less),
        .o_IsLessUnsigned (is_less_unsigned)
    );

    assign less = (stage_q.kind == CMP_UNSIGNED) ? is_less_unsigned : is_less;

    // A refill from the stage takes priority over a drain in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rsp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_result_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stage_q.valid && stage_q.id == ID_W'(i)) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_result_q[i] <= less ? LESS_TRUE : LESS_FALSE;
                end else if (rsp_valid_q[i] && bus.i_RspReady[i]) begin
                    rsp_valid_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.o_ReqReady = grant;
    assign bus.o_RspValid = rsp_valid_q;
    assign bus.o_Busy     = stage_q.valid || (|rsp_valid_q);

endmodule

// File: tb/tb_set_less_arbiter.sv
// Self-checking bench for set_less_arbiter: directed scenarios plus a randomized run
// checked against a round-robin / less-than reference model.
module tb_set_less_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    set_less_arbiter_if #(.NUM_REQ(N), .WIDTH(32)) bus ();

    set_less_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (32)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_ReqValid    = '0;
        bus.i_ReqA        = '0;
        bus.i_ReqB        = '0;
        bus.i_ReqUnsigned = '0;
        bus.i_RspReady    = '0;
    endtask

    task automatic apply_stimulus(input int i, input logic v, input logic [31:0] a,
                                  input logic [31:0] b, input logic u);
        bus.i_ReqValid[i]     = v;
        bus.i_ReqA[32*i +: 32] = a;
        bus.i_ReqB[32*i +: 32] = b;
        bus.i_ReqUnsigned[i]  = u;
    endtask

    function automatic logic [31:0] ref_less(input logic [31:0] a, input logic [31:0] b,
                                             input logic u);
        logic lt;
        lt = u ? (a < b) : ($signed(a) < $signed(b));
        return lt ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 3));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 3));
            default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.i_RspReady = '1;
        apply_stimulus(0, 1'b1, 32'h1, 32'h2, 1'b0);
        next_cycle();
        vectors++;
        if (bus.o_ReqReady !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got %b want 000", bus.o_ReqReady);
        end
        next_cycle();
        vectors++;
        if (bus.o_RspValid !== 3'b000 || bus.o_RspResult !== '0 || bus.o_Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got rv=%b res=%h busy=%b want 0/0/0",
                     bus.o_RspValid, bus.o_RspResult, bus.o_Busy);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic single_op(input logic u, input logic [31:0] expected, input string name);
        do_reset();
        apply_stimulus(0, 1'b1, 32'hFFFF_FFFF, 32'h1, u);
        #1;
        vectors++;
        if (bus.o_ReqReady !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL %s_ready got %b want 001", name, bus.o_ReqReady);
        end
        next_cycle();
        apply_stimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
        vectors++;
        if (bus.o_RspValid[0] !== 1'b0 || bus.o_Busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_stage got rv=%b busy=%b want 0/1", name, bus.o_RspValid[0], bus.o_Busy);
        end
        next_cycle();
        vectors++;
        if (bus.o_RspValid[0] !== 1'b1 || bus.o_RspResult[31:0] !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s_result got rv=%b res=%h want 1/%h", name,
                     bus.o_RspValid[0], bus.o_RspResult[31:0], expected);
        end
        bus.i_RspReady = '1;
        next_cycle();
        vectors++;
        if (bus.o_RspValid !== 3'b000 || bus.o_Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain got rv=%b busy=%b want 000/0", name, bus.o_RspValid, bus.o_Busy);
        end
    endtask

    task automatic test_single();
        single_op(1'b0, 32'h1, "single_signed");
        single_op(1'b1, 32'h0, "single_unsigned");
    endtask

    task automatic test_alternate();
        logic [2:0] exp_ready;
        logic       exp_rv1;
        do_reset();
        bus.i_RspReady = '1;
        apply_stimulus(0, 1'b1, 32'd5, 32'd3, 1'b0);
        apply_stimulus(1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_ready = (c % 2 == 0) ? 3'b001 : 3'b010;
            exp_rv1   = (c >= 3) && (c % 2 == 1);
            vectors++;
            if (bus.o_ReqReady !== exp_ready) begin
                miscompares++;
                $display("[TB] FAIL alt_grant c=%0d got %b want %b", c, bus.o_ReqReady, exp_ready);
            end
            vectors++;
            if (bus.o_RspValid[1] !== exp_rv1 || (exp_rv1 && bus.o_RspResult[63:32] !== 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL alt_rsp1 c=%0d got rv=%b res=%h want %b/0", c,
                         bus.o_RspValid[1], bus.o_RspResult[63:32], exp_rv1);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_ready;
        do_reset();
        bus.i_RspReady = 3'b001;
        apply_stimulus(0, 1'b1, 32'd7, 32'd9, 1'b1);
        apply_stimulus(1, 1'b1, 32'd1, 32'd2, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c == 0)           exp_ready = 3'b001;
            else if (c == 1)      exp_ready = 3'b010;
            else if (c % 2 == 0)  exp_ready = 3'b001;
            else                  exp_ready = 3'b000;
            vectors++;
            if (bus.o_ReqReady !== exp_ready) begin
                miscompares++;
                $display("[TB] FAIL bp_grant c=%0d got %b want %b", c, bus.o_ReqReady, exp_ready);
            end
            if (c >= 3) begin
                vectors++;
                if (bus.o_RspValid[1] !== 1'b1 || bus.o_RspResult[63:32] !== 32'h1) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold c=%0d got rv=%b res=%h want 1/1", c,
                             bus.o_RspValid[1], bus.o_RspResult[63:32]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_rdy;
        logic       exp_rv;
        logic [31:0] exp_res;
        do_reset();
        bus.i_RspReady = '1;
        apply_stimulus(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) apply_stimulus(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0);
            if (c == 3) apply_stimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            exp_rdy = (c == 0) || (c == 2);
            exp_rv  = (c == 2) || (c == 4);
            exp_res = (c == 2) ? 32'h1 : 32'h0;
            vectors++;
            if (bus.o_ReqReady[0] !== exp_rdy) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready c=%0d got %b want %b", c, bus.o_ReqReady[0], exp_rdy);
            end
            vectors++;
            if (bus.o_RspValid[0] !== exp_rv || (exp_rv && bus.o_RspResult[31:0] !== exp_res)) begin
                miscompares++;
                $display("[TB] FAIL b2b_rsp c=%0d got rv=%b res=%h want %b/%h", c,
                         bus.o_RspValid[0], bus.o_RspResult[31:0], exp_rv, exp_res);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_RspReady = '1;
        apply_stimulus(0, 1'b1, 32'd3, 32'd4, 1'b0);
        apply_stimulus(1, 1'b1, 32'd3, 32'd4, 1'b0);
        next_cycle();
        apply_stimulus(1, 1'b1, 32'd3, 32'd4, 1'b0);
        next_cycle();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.o_ReqReady !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL mid_rst_ready got %b want 000", bus.o_ReqReady);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.o_RspValid !== 3'b000 || bus.o_Busy !== 1'b0 || bus.o_ReqReady !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL mid_rst_after got rv=%b busy=%b rdy=%b want 000/0/001",
                     bus.o_RspValid, bus.o_Busy, bus.o_ReqReady);
        end
        next_cycle();
        apply_stimulus(0, 1'b0, 32'd0, 32'd0, 1'b0);
        apply_stimulus(1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (bus.o_RspValid !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL mid_rst_stale got %b want 000", bus.o_RspValid);
        end
        next_cycle();
        next_cycle();
        vectors++;
        if (bus.o_Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_rst_idle got busy=%b want 0", bus.o_Busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] ha [N];
        logic [31:0] hb [N];
        logic        hu [N];
        bit          hv [N];
        bit          m_stage [N];
        bit          m_full [N];
        logic [31:0] q [N][$];
        logic [N-1:0] rr;
        logic [N-1:0] eg;
        logic [N-1:0] m_rv;
        logic         m_busy;
        logic [31:0]  exp_res;
        int           m_ptr;
        int           grants;
        int           cycles;
        int           idx;
        bit           found;
        do_reset();
        m_ptr  = 0;
        grants = 0;
        cycles = 0;
        for (int i = 0; i < N; i++) begin
            hv[i] = 0; m_stage[i] = 0; m_full[i] = 0; q[i].delete();
        end
        while (grants < 20000 && cycles < 50000) begin
            for (int i = 0; i < N; i++) begin
                if (!hv[i] && $urandom_range(0, 3) != 0) begin
                    hv[i] = 1;
                    ha[i] = rand_word();
                    hb[i] = ($urandom_range(0, 7) == 0) ? ha[i] : rand_word();
                    hu[i] = 1'($urandom_range(0, 1));
                end
                apply_stimulus(i, hv[i], ha[i], hb[i], hu[i]);
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            bus.i_RspReady = rr;
            #1;
            eg = '0;
            found = 0;
            m_busy = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && hv[idx] && !m_stage[idx] && (!m_full[idx] || rr[idx])) begin
                    eg[idx] = 1'b1;
                    found = 1;
                end
                m_rv[k] = m_full[k];
                m_busy = m_busy | m_full[k] | m_stage[k];
            end
            vectors++;
            if (bus.o_ReqReady !== eg || bus.o_RspValid !== m_rv || bus.o_Busy !== m_busy) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl cyc=%0d got rdy=%b rv=%b busy=%b want %b/%b/%b",
                         cycles, bus.o_ReqReady, bus.o_RspValid, bus.o_Busy, eg, m_rv, m_busy);
            end
            for (int i = 0; i < N; i++) begin
                if (m_full[i] && rr[i] && q[i].size() > 0) begin
                    exp_res = q[i].pop_front();
                    vectors++;
                    if (bus.o_RspResult[32*i +: 32] !== exp_res) begin
                        miscompares++;
                        $display("[TB] FAIL rand_result req=%0d got %h want %h", i,
                                 bus.o_RspResult[32*i +: 32], exp_res);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                m_full[i]  = m_stage[i] ? 1'b1 : (m_full[i] && !rr[i]);
                m_stage[i] = eg[i];
                if (eg[i]) begin
                    q[i].push_back(ref_less(ha[i], hb[i], hu[i]));
                    hv[i] = 0;
                    m_ptr = (i + 1) % N;
                    grants++;
                end
            end
            cycles++;
            next_cycle();
        end
        vectors++;
        if (grants < 20000) begin
            miscompares++;
            $display("[TB] FAIL rand_budget got %0d grants want 20000", grants);
        end
        clear_inputs();
        bus.i_RspReady = '1;
        next_cycle();
        next_cycle();
        next_cycle();
        vectors++;
        if (bus.o_Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_drain got busy=%b want 0", bus.o_Busy);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
